// File: rtl/gsm_egress_sched.sv
// Egress read scheduler for the grouped-share-memory central RAM: per-port cell-address
// queues, round-robin read arbitration, multicast reference counting and buffer release.
module gsm_egress_sched #(
  parameter int MWIDTH  = 4,
  parameter int CAWIDTH = 9,
  parameter int QAWIDTH = 4,
  parameter int RAM_LAT = 2
) (
  input  logic               clk_320M,
  input  logic               clr_320M,
  input  logic               i_enq,
  input  logic [CAWIDTH-1:0] i_enq_addr,
  input  logic [MWIDTH-1:0]  i_enq_multicast,
  input  logic [MWIDTH-1:0]  i_egress_stall,
  output logic               o_rd_en,
  output logic [CAWIDTH-1:0] o_rd_addr,
  output logic [MWIDTH-1:0]  o_rd_sel,
  output logic [MWIDTH-1:0]  o_egress_sel,
  output logic               o_buf_free,
  output logic [CAWIDTH-1:0] o_buf_free_addr,
  output logic               o_drop,
  output logic [MWIDTH-1:0]  o_q_full
);
  localparam int LOG_MWIDTH = (MWIDTH > 1) ? $clog2(MWIDTH) : 1;
  localparam int QDEPTH     = 1 << QAWIDTH;
  localparam int NCELL      = 1 << CAWIDTH;
  localparam int RCW        = LOG_MWIDTH + 1;

  function automatic logic [RCW-1:0] popcount(input logic [MWIDTH-1:0] m);
    logic [RCW-1:0] n;
    n = '0;
    for (int i = 0; i < MWIDTH; i++) n = n + RCW'(m[i]);
    return n;
  endfunction

  logic [CAWIDTH-1:0]    q_mem  [MWIDTH][QDEPTH];
  logic [QAWIDTH-1:0]    wr_ptr [MWIDTH];
  logic [QAWIDTH-1:0]    rd_ptr [MWIDTH];
  logic [QAWIDTH:0]      q_cnt  [MWIDTH];
  logic [RCW-1:0]        refcnt [NCELL];
  logic [LOG_MWIDTH-1:0] rr_ptr;
  logic                  pend_vld;
  logic [CAWIDTH-1:0]    pend_addr;

  logic                  vld_p1;
  logic [CAWIDTH-1:0]    rd_addr_p1;
  logic [MWIDTH-1:0]     rd_sel_p1;
  logic                  free_p1;
  logic [CAWIDTH-1:0]    free_addr_p1;
  logic                  drop_p1;
  logic [MWIDTH-1:0]     egress_sel_p [RAM_LAT];

  logic [MWIDTH-1:0]     q_full;
  logic [MWIDTH-1:0]     q_nonempty;
  logic [MWIDTH-1:0]     eligible;
  logic [MWIDTH-1:0]     push;
  logic [MWIDTH-1:0]     pop;
  logic                  enq_ok;
  logic                  enq_rej;
  logic                  grant_vld;
  logic [LOG_MWIDTH-1:0] grant_idx;
  logic [LOG_MWIDTH-1:0] scan_idx;
  logic [CAWIDTH-1:0]    head_addr;
  logic                  last_ref;

  always_comb begin
    for (int p = 0; p < MWIDTH; p++) begin
      q_full[p]     = (q_cnt[p] == (QAWIDTH+1)'(QDEPTH));
      q_nonempty[p] = (q_cnt[p] != '0);
    end
  end

  // Fullness is judged on pre-edge counts; a same-cycle pop never makes room.
  assign enq_ok   = i_enq && (i_enq_multicast != '0) && ((i_enq_multicast & q_full) == '0);
  assign enq_rej  = i_enq && !enq_ok;
  assign eligible = q_nonempty & ~i_egress_stall & {MWIDTH{~pend_vld}};

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int i = 0; i < MWIDTH; i++) begin
      scan_idx = rr_ptr + LOG_MWIDTH'(i);
      if (!grant_vld && eligible[scan_idx]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  assign head_addr = q_mem[grant_idx][rd_ptr[grant_idx]];
  assign last_ref  = grant_vld && (refcnt[head_addr] == RCW'(1));

  always_comb begin
    for (int p = 0; p < MWIDTH; p++) begin
      push[p] = enq_ok && i_enq_multicast[p];
      pop[p]  = grant_vld && (grant_idx == LOG_MWIDTH'(p));
    end
  end

  always_ff @(posedge clk_320M or posedge clr_320M) begin
    if (clr_320M) begin
      for (int p = 0; p < MWIDTH; p++) begin
        wr_ptr[p] <= '0;
        rd_ptr[p] <= '0;
        q_cnt[p]  <= '0;
      end
    end else begin
      for (int p = 0; p < MWIDTH; p++) begin
        if (push[p]) wr_ptr[p] <= wr_ptr[p] + QAWIDTH'(1);
        if (pop[p])  rd_ptr[p] <= rd_ptr[p] + QAWIDTH'(1);
        q_cnt[p] <= q_cnt[p] + (QAWIDTH+1)'(push[p]) - (QAWIDTH+1)'(pop[p]);
      end
    end
  end

  always_ff @(posedge clk_320M) begin
    for (int p = 0; p < MWIDTH; p++) begin
      if (push[p]) q_mem[p][wr_ptr[p]] <= i_enq_addr;
    end
  end

  // A live cell is never re-enqueued, so the decrement and the load hit different entries.
  always_ff @(posedge clk_320M or posedge clr_320M) begin
    if (clr_320M) begin
      for (int a = 0; a < NCELL; a++) refcnt[a] <= '0;
    end else begin
      if (grant_vld && !last_ref) refcnt[head_addr] <= refcnt[head_addr] - RCW'(1);
      if (enq_ok) refcnt[i_enq_addr] <= popcount(i_enq_multicast);
    end
  end

  // Stage p1: read strobe, free and drop pulses; egress select follows RAM_LAT stages later.
  always_ff @(posedge clk_320M or posedge clr_320M) begin
    if (clr_320M) begin
      rr_ptr       <= '0;
      pend_vld     <= 1'b0;
      pend_addr    <= '0;
      vld_p1       <= 1'b0;
      rd_addr_p1   <= '0;
      rd_sel_p1    <= '0;
      free_p1      <= 1'b0;
      free_addr_p1 <= '0;
      drop_p1      <= 1'b0;
      for (int i = 0; i < RAM_LAT; i++) egress_sel_p[i] <= '0;
    end else begin
      if (grant_vld) rr_ptr <= grant_idx + LOG_MWIDTH'(1);
      pend_vld <= enq_rej;
      if (enq_rej) pend_addr <= i_enq_addr;
      vld_p1    <= grant_vld;
      rd_sel_p1 <= grant_vld ? (MWIDTH'(1) << grant_idx) : '0;
      if (grant_vld) rd_addr_p1 <= head_addr;
      free_p1 <= last_ref || pend_vld;
      if (last_ref)      free_addr_p1 <= head_addr;
      else if (pend_vld) free_addr_p1 <= pend_addr;
      drop_p1 <= enq_rej;
      egress_sel_p[0] <= rd_sel_p1;
      for (int i = 1; i < RAM_LAT; i++) egress_sel_p[i] <= egress_sel_p[i-1];
    end
  end

  assign o_rd_en         = vld_p1;
  assign o_rd_addr       = rd_addr_p1;
  assign o_rd_sel        = rd_sel_p1;
  assign o_egress_sel    = egress_sel_p[RAM_LAT-1];
  assign o_buf_free      = free_p1;
  assign o_buf_free_addr = free_addr_p1;
  assign o_drop          = drop_p1;
  assign o_q_full        = q_full;

endmodule

// File: tb/tb_gsm_egress_sched.sv
// Bench for gsm_egress_sched: directed scenarios plus randomized traffic against a
// queue-based reference model of the scheduler.
module tb_gsm_egress_sched;
  logic       clk;
  logic       rst;
  logic       enq;
  logic [8:0] enq_addr;
  logic [3:0] mask;
  logic [3:0] stall;
  logic       o_rd_en;
  logic [8:0] o_rd_addr;
  logic [3:0] o_rd_sel;
  logic [3:0] o_egress_sel;
  logic       o_buf_free;
  logic [8:0] o_buf_free_addr;
  logic       o_drop;
  logic [3:0] o_q_full;

  int errors;
  int checks;

  gsm_egress_sched #(.MWIDTH(4), .CAWIDTH(9), .QAWIDTH(4), .RAM_LAT(2)) dut (
    .clk_320M(clk), .clr_320M(rst), .i_enq(enq), .i_enq_addr(enq_addr),
    .i_enq_multicast(mask), .i_egress_stall(stall), .o_rd_en(o_rd_en),
    .o_rd_addr(o_rd_addr), .o_rd_sel(o_rd_sel), .o_egress_sel(o_egress_sel),
    .o_buf_free(o_buf_free), .o_buf_free_addr(o_buf_free_addr), .o_drop(o_drop),
    .o_q_full(o_q_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  int   mq [4][$];
  int   mrc [int];
  bit   live [int];
  int   mptr;
  bit   mpend_v;
  int   mpend_a;
  logic [3:0] hist0, hist1;
  logic       e_rd_en;
  logic [8:0] e_rd_addr;
  logic [3:0] e_rd_sel;
  logic [3:0] e_egress;
  logic [3:0] e_qfull;
  logic       e_free;
  logic [8:0] e_free_addr;
  logic       e_drop;

  task automatic model_clear();
    for (int p = 0; p < 4; p++) mq[p].delete();
    mrc.delete();
    live.delete();
    mptr = 0; mpend_v = 0; mpend_a = 0; hist0 = '0; hist1 = '0;
  endtask

  // Advance one clock edge with the current inputs, updating the model alongside.
  task automatic cyc();
    bit gv, acc;
    int g, head;
    gv = 0; g = 0; head = 0;
    for (int i = 0; i < 4; i++) begin
      int p;
      p = (mptr + i) % 4;
      if (!gv && mq[p].size() > 0 && !stall[p] && !mpend_v) begin gv = 1; g = p; end
    end
    acc = enq && (mask != 4'b0);
    for (int p = 0; p < 4; p++) if (mask[p] && mq[p].size() >= 16) acc = 0;
    e_rd_en = gv;
    e_rd_sel = gv ? 4'(1 << g) : 4'b0;
    e_free = 0;
    e_free_addr = '0;
    if (gv) begin
      head = mq[g].pop_front();
      e_rd_addr = 9'(head);
      mptr = (g + 1) % 4;
      if (mrc[head] == 1) begin
        e_free = 1; e_free_addr = 9'(head); mrc.delete(head); live.delete(head);
      end else mrc[head] = mrc[head] - 1;
    end else if (mpend_v) begin
      e_free = 1; e_free_addr = 9'(mpend_a); live.delete(mpend_a);
    end
    if (enq) live[int'(enq_addr)] = 1;
    if (acc) begin
      for (int p = 0; p < 4; p++) if (mask[p]) mq[p].push_back(int'(enq_addr));
      mrc[int'(enq_addr)] = $countones(mask);
    end
    e_drop = enq && !acc;
    mpend_v = e_drop;
    mpend_a = int'(enq_addr);
    e_egress = hist1; hist1 = hist0; hist0 = e_rd_sel;
    for (int p = 0; p < 4; p++) e_qfull[p] = (mq[p].size() == 16);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; enq = 0; enq_addr = '0; mask = '0; stall = '0;
    @(negedge clk);
    rst = 0;
    model_clear();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1; enq = 0; enq_addr = '0; mask = '0; stall = '0;
    #1;
    checks++;
    if ({o_rd_en, o_rd_addr, o_rd_sel, o_egress_sel, o_buf_free, o_buf_free_addr, o_drop, o_q_full} !== 33'b0) begin
      errors++; $display("FAIL reset_outputs: got rd_en=%b sel=%b free=%b drop=%b full=%b want all 0", o_rd_en, o_rd_sel, o_buf_free, o_drop, o_q_full);
    end
    @(negedge clk); rst = 0; model_clear();
    cyc();
    checks++;
    if ({o_rd_en, o_buf_free, o_drop, o_q_full} !== 7'b0) begin
      errors++; $display("FAIL reset_idle: got rd_en=%b free=%b drop=%b full=%b want 0", o_rd_en, o_buf_free, o_drop, o_q_full);
    end
  endtask

  task automatic test_unicast();
    do_reset();
    enq = 1; enq_addr = 9'h005; mask = 4'b0001; cyc();
    enq = 0; mask = '0;
    checks++;
    if (o_rd_en !== 1'b0) begin errors++; $display("FAIL uni_no_early_read: got %b want 0", o_rd_en); end
    cyc();
    checks++;
    if ({o_rd_en, o_rd_addr, o_rd_sel} !== {1'b1, 9'h005, 4'b0001}) begin
      errors++; $display("FAIL uni_read: got en=%b addr=%h sel=%b want 1 005 0001", o_rd_en, o_rd_addr, o_rd_sel);
    end
    checks++;
    if ({o_buf_free, o_buf_free_addr} !== {1'b1, 9'h005}) begin
      errors++; $display("FAIL uni_free: got %b %h want 1 005", o_buf_free, o_buf_free_addr);
    end
    cyc();
    checks++;
    if (o_egress_sel !== 4'b0000) begin errors++; $display("FAIL uni_egress_c3: got %b want 0000", o_egress_sel); end
    cyc();
    checks++;
    if (o_egress_sel !== 4'b0001) begin errors++; $display("FAIL uni_egress_c4: got %b want 0001", o_egress_sel); end
  endtask

  task automatic test_multicast();
    do_reset();
    enq = 1; enq_addr = 9'h010; mask = 4'b1111; cyc();
    enq = 0; mask = '0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      checks++;
      if ({o_rd_en, o_rd_addr, o_rd_sel} !== {1'b1, 9'h010, 4'(1 << k)}) begin
        errors++; $display("FAIL mc_read[%0d]: got en=%b addr=%h sel=%b want 1 010 %b", k, o_rd_en, o_rd_addr, o_rd_sel, 4'(1 << k));
      end
      checks++;
      if (o_buf_free !== (k == 3)) begin
        errors++; $display("FAIL mc_free[%0d]: got %b want %b", k, o_buf_free, (k == 3));
      end
    end
    checks++;
    if (o_buf_free_addr !== 9'h010) begin errors++; $display("FAIL mc_free_addr: got %h want 010", o_buf_free_addr); end
    cyc();
    checks++;
    if (o_rd_en !== 1'b0) begin errors++; $display("FAIL mc_idle: got %b want 0", o_rd_en); end
  endtask

  task automatic test_fairness();
    int frees;
    frees = 0;
    do_reset();
    stall = 4'b1111;
    for (int i = 0; i < 12; i++) begin
      enq = 1; enq_addr = 9'(9'h040 + i); mask = 4'(1 << (i % 4)); cyc();
    end
    enq = 0; mask = '0; stall = 4'b0000;
    for (int k = 0; k < 12; k++) begin
      cyc();
      checks++;
      if ({o_rd_en, o_rd_sel} !== {1'b1, 4'(1 << (k % 4))}) begin
        errors++; $display("FAIL fair_order[%0d]: got en=%b sel=%b want 1 %b", k, o_rd_en, o_rd_sel, 4'(1 << (k % 4)));
      end
      if (o_buf_free) frees++;
    end
    cyc();
    checks++;
    if (frees != 12 || o_rd_en !== 1'b0) begin
      errors++; $display("FAIL fair_frees: got frees=%0d trailing_rd=%b want 12 0", frees, o_rd_en);
    end
  endtask

  task automatic test_stall();
    int reads;
    bit found;
    reads = 0; found = 0;
    do_reset();
    stall = 4'b1111;
    for (int i = 0; i < 16; i++) begin
      enq = 1; enq_addr = 9'(9'h020 + i); mask = 4'(1 << (i % 4)); cyc();
    end
    enq = 0; mask = '0; stall = 4'b0010;
    for (int k = 0; k < 10; k++) begin
      cyc();
      checks++;
      if (o_rd_sel[1] !== 1'b0) begin errors++; $display("FAIL stall_port1[%0d]: got sel=%b want bit1 0", k, o_rd_sel); end
      if (o_rd_en) reads++;
    end
    checks++;
    if (reads != 10) begin errors++; $display("FAIL stall_others: got %0d reads want 10", reads); end
    stall = 4'b0000;
    for (int k = 0; k < 4 && !found; k++) begin
      cyc();
      if (o_rd_sel == 4'b0010) found = 1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL stall_release: got no port1 read in 4 cycles want one"); end
    for (int k = 0; k < 8; k++) cyc();
  endtask

  task automatic test_full_drop();
    int p1_reads, p2_reads;
    p1_reads = 0; p2_reads = 0;
    do_reset();
    stall = 4'b1111;
    for (int i = 0; i < 18; i++) begin
      enq = 1;
      enq_addr = (i < 2) ? 9'(9'h080 + i) : 9'(9'h100 + i - 2);
      mask = (i < 2) ? 4'b0001 : 4'b0100;
      cyc();
    end
    checks++;
    if (o_q_full !== 4'b0100) begin errors++; $display("FAIL full_flag: got %b want 0100", o_q_full); end
    enq = 1; enq_addr = 9'h0AA; mask = 4'b0110; stall = 4'b0100; cyc();
    enq = 0; mask = '0;
    checks++;
    if ({o_drop, o_rd_en, o_rd_sel, o_rd_addr} !== {1'b1, 1'b1, 4'b0001, 9'h080}) begin
      errors++; $display("FAIL drop_t1: got drop=%b en=%b sel=%b addr=%h want 1 1 0001 080", o_drop, o_rd_en, o_rd_sel, o_rd_addr);
    end
    checks++;
    if ({o_buf_free, o_buf_free_addr, o_q_full} !== {1'b1, 9'h080, 4'b0100}) begin
      errors++; $display("FAIL drop_t1_free: got free=%b addr=%h full=%b want 1 080 0100", o_buf_free, o_buf_free_addr, o_q_full);
    end
    cyc();
    checks++;
    if ({o_drop, o_rd_en, o_buf_free, o_buf_free_addr} !== {1'b0, 1'b0, 1'b1, 9'h0AA}) begin
      errors++; $display("FAIL drop_gap: got drop=%b en=%b free=%b addr=%h want 0 0 1 0aa", o_drop, o_rd_en, o_buf_free, o_buf_free_addr);
    end
    cyc();
    checks++;
    if ({o_rd_en, o_rd_sel, o_rd_addr} !== {1'b1, 4'b0001, 9'h081}) begin
      errors++; $display("FAIL drop_resume: got en=%b sel=%b addr=%h want 1 0001 081", o_rd_en, o_rd_sel, o_rd_addr);
    end
    stall = 4'b0000;
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (o_rd_sel == 4'b0010) p1_reads++;
      if (o_rd_sel == 4'b0100) p2_reads++;
    end
    checks++;
    if (p1_reads != 0 || p2_reads != 16 || o_q_full !== 4'b0000) begin
      errors++; $display("FAIL drop_drain: got p1=%0d p2=%0d full=%b want 0 16 0000", p1_reads, p2_reads, o_q_full);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    enq = 1; enq_addr = 9'h010; mask = 4'b1111; cyc();
    enq = 0; mask = '0;
    cyc();
    cyc();
    checks++;
    if (o_rd_sel !== 4'b0010) begin errors++; $display("FAIL rstmid_pre: got sel=%b want 0010", o_rd_sel); end
    #2 rst = 1;
    #1;
    checks++;
    if ({o_rd_en, o_rd_addr, o_rd_sel, o_egress_sel, o_buf_free, o_buf_free_addr, o_drop, o_q_full} !== 33'b0) begin
      errors++; $display("FAIL rstmid_outputs: got en=%b sel=%b egr=%b free=%b want all 0", o_rd_en, o_rd_sel, o_egress_sel, o_buf_free);
    end
    @(negedge clk); rst = 0; model_clear();
    enq = 1; enq_addr = 9'h001; mask = 4'b0001; cyc();
    enq = 0; mask = '0;
    cyc();
    checks++;
    if ({o_rd_en, o_rd_sel, o_rd_addr, o_buf_free, o_buf_free_addr} !== {1'b1, 4'b0001, 9'h001, 1'b1, 9'h001}) begin
      errors++; $display("FAIL rstmid_after: got en=%b sel=%b addr=%h free=%b faddr=%h want 1 0001 001 1 001", o_rd_en, o_rd_sel, o_rd_addr, o_buf_free, o_buf_free_addr);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 900; n++) begin
      if (n < 800) begin
        stall = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
        enq = ($urandom_range(0, 3) != 0);
        mask = ($urandom_range(0, 15) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
        do enq_addr = 9'($urandom_range(0, 511)); while (live.exists(int'(enq_addr)));
      end else begin
        stall = '0; enq = 0; mask = '0;
      end
      cyc();
      checks++;
      if ({o_rd_en, o_rd_sel} !== {e_rd_en, e_rd_sel}) begin
        errors++; $display("FAIL rand_read[%0d]: got en=%b sel=%b want %b %b", n, o_rd_en, o_rd_sel, e_rd_en, e_rd_sel);
      end
      if (e_rd_en) begin
        checks++;
        if (o_rd_addr !== e_rd_addr) begin errors++; $display("FAIL rand_rd_addr[%0d]: got %h want %h", n, o_rd_addr, e_rd_addr); end
      end
      checks++;
      if ({o_buf_free, o_drop, o_q_full, o_egress_sel} !== {e_free, e_drop, e_qfull, e_egress}) begin
        errors++; $display("FAIL rand_flags[%0d]: got free=%b drop=%b full=%b egr=%b want %b %b %b %b", n, o_buf_free, o_drop, o_q_full, o_egress_sel, e_free, e_drop, e_qfull, e_egress);
      end
      if (e_free) begin
        checks++;
        if (o_buf_free_addr !== e_free_addr) begin errors++; $display("FAIL rand_free_addr[%0d]: got %h want %h", n, o_buf_free_addr, e_free_addr); end
      end
    end
  endtask

  initial begin
    errors = 0; checks = 0;
    rst = 1; enq = 0; enq_addr = '0; mask = '0; stall = '0;
    model_clear();
    test_reset();
    test_unicast();
    test_multicast();
    test_fairness();
    test_stall();
    test_full_drop();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got simulation still running want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
